// File: rtl/correction_frame_ctrl.sv
`default_nettype none
// ============================================================================
// correction_frame_ctrl
//   Ping-pong frame sequencer: write addressing and complete-frame readout.
//   Rev 1.0
// ============================================================================
module correction_frame_ctrl #(
    parameter int ADDR_W       = 18,
    parameter int FRAME_PIXELS = 131072,
    parameter int RD_LAT       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              din_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_cnt,
    output logic [ADDR_W-1:0] rd_base,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_ACTIVE = 2'd1;
    localparam logic [1:0] RD_DONE   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_PIXELS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              last_bank_q, last_bank_d;
    logic [7:0]        drop_q, drop_d;
    logic [RD_LAT-1:0] lat_q;

    logic [ADDR_W-1:0] wr_idx;
    logic              new_frame;
    logic              sel_bank;
    logic              cur_bank;
    logic              wr_drop;
    logic              rd_drop;
    logic              rd_pick;
    logic [1:0]        eligible;

    // sof forces index 0 so a coincident pixel opens a fresh bank
    always_comb begin
        wr_idx    = sof ? '0 : wr_cnt_q;
        new_frame = (wr_idx == '0);
        if (state_q != RD_IDLE) begin
            sel_bank = ~rd_bank_q;
        end else if (full_q[0] != full_q[1]) begin
            sel_bank = full_q[0];
        end else begin
            sel_bank = ~last_bank_q;
        end
        cur_bank = new_frame ? sel_bank : wr_bank_q;
        wr_drop  = din_valid && new_frame && full_q[sel_bank];

        eligible[0] = full_q[0] && !(wr_bank_q == 1'b0 && wr_cnt_q != '0);
        eligible[1] = full_q[1] && !(wr_bank_q == 1'b1 && wr_cnt_q != '0);
        rd_drop     = (state_q == RD_IDLE) && (&eligible);
        rd_pick     = (&eligible) ? last_bank_q : eligible[1];
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        last_bank_d = last_bank_q;
        drop_d      = drop_q;

        case (state_q)
            RD_IDLE: begin
                if (|eligible) begin
                    state_d   = RD_ACTIVE;
                    rd_bank_d = rd_pick;
                    rd_cnt_d  = '0;
                    if (rd_drop) begin
                        full_d[~last_bank_q] = 1'b0;
                    end
                end
            end
            RD_ACTIVE: begin
                if (rd_req) begin
                    if (rd_cnt_q == LAST_PIX) begin
                        state_d = RD_DONE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    end
                end
            end
            RD_DONE: begin
                full_d[rd_bank_q] = 1'b0;
                rd_cnt_d          = '0;
                state_d           = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase

        if (sof) begin
            wr_cnt_d = '0;
        end
        // Writer never targets the bank under readout, so its set cannot collide with RD_DONE's clear
        if (din_valid) begin
            if (new_frame) begin
                wr_bank_d        = sel_bank;
                full_d[sel_bank] = 1'b0;
            end
            if (wr_idx == LAST_PIX) begin
                full_d[cur_bank] = 1'b1;
                last_bank_d      = cur_bank;
                wr_cnt_d         = '0;
            end else begin
                wr_cnt_d = wr_idx + ADDR_W'(1);
            end
        end

        if ((wr_drop || rd_drop) && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RD_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            last_bank_q <= 1'b1;
            drop_q      <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            last_bank_q <= last_bank_d;
            drop_q      <= drop_d;
            lat_q       <= RD_LAT'({lat_q, rd_en});
        end
    end

    assign wr_en      = din_valid && rst;
    assign wr_addr    = (cur_bank ? BANK1_BASE : '0) + wr_idx;
    assign rd_en      = (state_q == RD_ACTIVE) && rd_req;
    assign rd_cnt     = rd_cnt_q;
    assign rd_base    = rd_bank_q ? BANK1_BASE : '0;
    assign dout_valid = lat_q[RD_LAT-1];
    assign frame_done = (state_q == RD_DONE);
    assign busy       = (state_q != RD_IDLE);
    assign drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_correction_frame_ctrl.sv
`default_nettype none
// tb_correction_frame_ctrl: randomized stimulus, frame-level reference model and
// a scoreboard that compares write addresses and delivered pixel data.
module tb_correction_frame_ctrl;
    localparam int ADDR_W = 6;
    localparam int FP     = 16;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sof = 1'b0;
    logic din_valid = 1'b0;
    logic rd_req = 1'b0;
    logic [15:0] pix = '0;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_base;
    logic              dout_valid;
    logic              frame_done;
    logic              busy;
    logic [7:0]        drop_cnt;

    correction_frame_ctrl #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FP),
        .RD_LAT       (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .din_valid  (din_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_req     (rd_req),
        .rd_en      (rd_en),
        .rd_cnt     (rd_cnt),
        .rd_base    (rd_base),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // ---------------- reference model (frames, not registers) ----------------
    logic [15:0] exp_q[$];
    int          wq[$];
    logic [15:0] m_wr[$];
    logic [15:0] m_wait_pix[$];
    logic [15:0] m_rd_pix[$];
    int m_wr_bank, m_wait_bank, m_rd_bank, m_last_bank, m_rd_left;
    bit m_wait_valid, m_wait_new, m_rd_busy;
    int m_drops, m_done;

    task automatic model_reset();
        exp_q.delete(); wq.delete(); m_wr.delete(); m_wait_pix.delete(); m_rd_pix.delete();
        m_wr_bank = 0; m_wait_bank = 0; m_rd_bank = 0; m_last_bank = 1; m_rd_left = 0;
        m_wait_valid = 0; m_wait_new = 0; m_rd_busy = 0;
        m_drops = 0; m_done = 0;
    endtask

    task automatic model_step(input logic s, input logic dv, input logic rq, input logic [15:0] p);
        bit busy_pre;
        busy_pre = m_rd_busy;
        if (s) m_wr.delete();
        if (dv) begin
            if (m_wr.size() == 0) begin
                // a new frame lands in the bank not being read; a waiting frame there is lost
                if (busy_pre) begin
                    m_wr_bank = 1 - m_rd_bank;
                    if (m_wait_valid && m_wait_bank == m_wr_bank) begin
                        m_wait_valid = 0;
                        if (m_drops < 255) m_drops++;
                    end
                end else if (m_wait_valid) begin
                    m_wr_bank = 1 - m_wait_bank;
                end else begin
                    m_wr_bank = 1 - m_last_bank;
                end
            end
            wq.push_back(m_wr_bank * FP + m_wr.size());
            m_wr.push_back(p);
            if (m_wr.size() == FP) begin
                m_wait_valid = 1; m_wait_new = 1; m_wait_bank = m_wr_bank;
                m_wait_pix = m_wr; m_last_bank = m_wr_bank;
                m_wr.delete();
            end
        end
        if (m_rd_busy) begin
            if (m_rd_left > 0) begin
                if (rq) begin
                    exp_q.push_back(m_rd_pix[FP - m_rd_left]);
                    m_rd_left--;
                end
            end else begin
                m_rd_busy = 0;
                m_done++;
            end
        end else if (m_wait_valid && !m_wait_new) begin
            m_rd_busy = 1; m_rd_bank = m_wait_bank; m_rd_pix = m_wait_pix;
            m_rd_left = FP; m_wait_valid = 0;
        end
        m_wait_new = 0;
    endtask

    // ---------------- monitor: BRAM model + scoreboard ----------------
    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic [15:0]       rdq[$];
    logic [RD_LAT-1:0] hist = '0;
    int                done_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rdq.delete();
            hist = '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] = pix;
                if (wq.size() == 0) fail_now("wr_unexpected");
                else check("wr_addr", 32'(wr_addr), 32'(wq.pop_front()));
            end
            if (rd_en) rdq.push_back(mem[rd_base + rd_cnt]);
            check("dout_valid_lag", 32'(dout_valid), 32'(hist[RD_LAT-1]));
            hist = {hist[RD_LAT-2:0], rd_en};
            if (dout_valid) begin
                if (rdq.size() == 0 || exp_q.size() == 0) fail_now("pixel_unexpected");
                else check("pixel", 32'(rdq.pop_front()), 32'(exp_q.pop_front()));
            end
            if (frame_done) done_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic dv, input logic rq);
        logic [15:0] p;
        @(posedge clk);
        #1;
        p = 16'($urandom);
        sof = s; din_valid = dv; rd_req = rq; pix = p;
        model_step(s, dv, rq, p);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b0; sof = 1'b0; din_valid = 1'b0; rd_req = 1'b0;
        model_reset();
        done_seen = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic final_checks(input string tag);
        check({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_wr_drained"}, 32'(wq.size()), 32'd0);
        check({tag, "_drop_model"}, 32'(drop_cnt), 32'(m_drops));
        check({tag, "_done_model"}, 32'(done_seen), 32'(m_done));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        model_reset();

        // T1: reset held with active inputs
        rst = 1'b0; din_valid = 1'b1; rd_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("t1_reset_outputs",
              32'({wr_en, wr_addr, rd_en, rd_cnt, rd_base, dout_valid, frame_done, busy, drop_cnt}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; din_valid = 1'b0; rd_req = 1'b0;

        // T2: single frame then readout
        for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("t2_rd_en_early", 32'(rd_en), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("t2_rd_en_start", 32'(rd_en), 32'd1);
        check("t2_rd_cnt0", 32'(rd_cnt), 32'd0);
        check("t2_rd_base0", 32'(rd_base), 32'd0);

        // T3: second frame written during readout, then read from bank 1
        for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (rd_en) found = 1;
        end
        if (!found) fail_now("t3_second_read_timeout");
        else begin
            check("t3_rd_base1", 32'(rd_base), 32'(FP));
            check("t3_rd_cnt0", 32'(rd_cnt), 32'd0);
        end
        check("t3_drop0", 32'(drop_cnt), 32'd0);
        repeat (30) step(1'b0, 1'b0, 1'b1);
        final_checks("t3");

        // T4: overflow with reader stalled
        for (int i = 0; i < 3 * FP; i++) step(1'b0, 1'b1, 1'b0);
        check("t4_drop1", 32'(drop_cnt), 32'd1);
        repeat (3 * FP + 10) step(1'b0, 1'b0, 1'b1);
        final_checks("t4");

        // T5: sof after 7 pixels restarts the frame
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check("t5_no_readout", 32'(busy), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0, 1'b1);
        final_checks("t5");

        // T6: reset mid-readout
        for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (rd_en && rd_cnt == ADDR_W'(9)) found = 1;
        end
        if (!found) fail_now("t6_rd_cnt9_timeout");
        #1;
        rst = 1'b0;
        #1;
        check("t6_rd_en_reset", 32'(rd_en), 32'd0);
        check("t6_busy_reset", 32'(busy), 32'd0);
        model_reset();
        done_seen = 0;
        @(posedge clk);
        #1;
        rst = 1'b1; sof = 1'b0; din_valid = 1'b0; rd_req = 1'b0;
        repeat (5) step(1'b0, 1'b0, 1'b1);
        check("t6_idle_after", 32'(busy), 32'd0);
        check("t6_drop_after", 32'(drop_cnt), 32'd0);

        // drop counter saturation
        for (int f = 0; f < 258; f++)
            for (int i = 0; i < FP; i++) step(1'b0, 1'b1, 1'b0);
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        repeat (60) step(1'b0, 1'b0, 1'b1);
        final_checks("t6");

        // randomized traffic
        reset_dut();
        repeat (800) step(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0);
        repeat (80) step(1'b0, 1'b0, 1'b1);
        final_checks("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
